// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter; launches one byte per Tx_done
// handshake with a one-cycle gap so the transmitter enable clears first.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
   input  logic          flush,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          wr_overflow,
   output logic [7:0]    tx_data,
   output logic          tx_send_go,
   input  logic          tx_done,
   output logic          tx_busy
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      GAP
   } state_t;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   cnt;
   logic          wr_acc;
   logic          pop;

   assign full   = (cnt == FULL_CNT);
   assign empty  = (cnt == '0);
   assign count  = cnt;
   assign wr_acc = wr_en & ~full & ~flush;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // flush blocks a new launch but never aborts one in flight
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !flush) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: state_nxt = WAIT;
         WAIT: begin
            if (tx_done) begin
               state_nxt = GAP;
            end
         end
         GAP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         cnt <= cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         tx_send_go  <= 1'b0;
         tx_data     <= 8'h00;
         tx_busy     <= 1'b0;
         wr_overflow <= 1'b0;
      end else begin
         tx_send_go  <= pop;
         tx_busy     <= (state_nxt != IDLE);
         wr_overflow <= wr_en & full;
         if (pop) begin
            tx_data <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter
// that returns tx_done a programmable number of cycles after launch.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          n_reset = 1'b1;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_en = 1'b0;
   logic          flush = 1'b0;
   logic          tx_done = 1'b0;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          wr_overflow;
   logic [7:0]    tx_data;
   logic          tx_send_go;
   logic          tx_busy;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .flush      (flush),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .wr_overflow(wr_overflow),
      .tx_data    (tx_data),
      .tx_send_go (tx_send_go),
      .tx_done    (tx_done),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         mcount = 0;
   int         timer = 0;
   int         done_dly = 5;
   int         post_done = 0;
   int         last_done = 0;
   int         cnt_at_done = 0;
   int         launches = 0;
   int         dones = 0;
   int         ovf_seen = 0;
   bit         mbusy = 0;
   bit         inflight = 0;
   bit         done_seen = 0;
   bit         tx_auto = 1;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic model_clear();
      mcount    = 0;
      timer     = 0;
      post_done = 0;
      mbusy     = 0;
      inflight  = 0;
      done_seen = 0;
      exp_q.delete();
   endtask

   // one clock: predict from inputs, clock, then compare
   task automatic tick();
      bit         acc;
      bit         ovf_exp;
      bit         done_now;
      int         pre_cnt;
      logic [7:0] b;
      acc      = wr_en && !flush && (mcount < DEPTH);
      ovf_exp  = wr_en && (mcount == DEPTH);
      done_now = tx_done;
      pre_cnt  = mcount;
      if (flush) exp_q.delete();
      if (acc) exp_q.push_back(wr_data);
      @(posedge clk);
      #1;
      cyc++;
      if (done_now) begin
         last_done   = cyc - 1;
         cnt_at_done = pre_cnt;
         done_seen   = 1;
         inflight    = 0;
         post_done   = 2;
         dones++;
      end
      if (post_done > 0) begin
         post_done--;
         if (post_done == 0) mbusy = 0;
      end
      if (flush) mcount = 0;
      else mcount = mcount + int'(acc) - int'(tx_send_go);
      if (tx_send_go) begin
         launches++;
         chk("no_early_launch", 32'(inflight), 0);
         if (done_seen && cnt_at_done > 0)
            chk("launch_gap", cyc - last_done, 3);
         done_seen = 0;
         if (exp_q.size() == 0) begin
            chk("spurious_launch", 1, 0);
         end else begin
            b = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(b));
         end
         inflight = 1;
         mbusy    = 1;
         timer    = done_dly;
      end
      if (wr_overflow) ovf_seen++;
      chk("count", 32'(count), mcount);
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("full", 32'(full), 32'(mcount == DEPTH));
      chk("wr_overflow", 32'(wr_overflow), 32'(ovf_exp));
      chk("tx_busy", 32'(tx_busy), 32'(mbusy));
      tx_done = 1'b0;
      if (inflight && tx_auto && !tx_send_go) begin
         if (timer > 0) timer--;
         if (timer == 0) tx_done = 1'b1;
      end
   endtask

   task automatic do_reset();
      #3;
      n_reset = 1'b0;
      wr_en   = 1'b0;
      flush   = 1'b0;
      tx_done = 1'b0;
      #1;
      chk("rst_send_go", 32'(tx_send_go), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_ovf", 32'(wr_overflow), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_reset = 1'b1;
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while (!(mcount == 0 && !mbusy && !inflight) && k < limit) begin
         tick();
         k++;
      end
      chk("idle_timeout", 32'(k < limit), 1);
   endtask

   task automatic write_burst(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = first + 8'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   initial begin
      int sent;
      int l0;
      int d0;
      do_reset();

      // single byte latency
      done_dly = 5;
      wr_en    = 1'b1;
      wr_data  = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("t1_count1", 32'(count), 1);
      tick();
      chk("t1_send_go", 32'(tx_send_go), 1);
      chk("t1_data", 32'(tx_data), 32'h A5);
      chk("t1_busy", 32'(tx_busy), 1);
      chk("t1_count0", 32'(count), 0);
      wait_idle(100);

      // back-to-back frames paced by tx_done
      done_dly = 100;
      l0 = launches;
      write_burst(8'h01, 4);
      wait_idle(1000);
      chk("t2_launches", launches - l0, 4);

      // fill to full with tx_done held off
      tx_auto  = 0;
      done_dly = 3;
      write_burst(8'h10, 17);
      tick();
      chk("t3_full", 32'(full), 1);
      chk("t3_count16", 32'(count), 16);
      ovf_seen = 0;
      wr_en    = 1'b1;
      wr_data  = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("t3_ovf_pulse", 32'(wr_overflow), 1);
      chk("t3_count_hold", 32'(count), 16);
      tick();
      chk("t3_ovf_once", ovf_seen, 1);
      // keep writing across a pop from full
      ovf_seen = 0;
      tx_auto  = 1;
      for (int i = 0; i < 20; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h80 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      chk("t3_ovf_on_pop", 32'(ovf_seen > 0), 1);
      wait_idle(2000);

      // pointer wrap, throttled by tx_done
      done_dly = 2;
      sent = 0;
      l0   = launches;
      for (int k = 0; k < 3000 && sent < 40; k++) begin
         if (mcount < DEPTH) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            sent++;
         end else begin
            wr_en = 1'b0;
         end
         tick();
      end
      wr_en = 1'b0;
      chk("t4_sent", sent, 40);
      wait_idle(2000);
      chk("t4_launches", launches - l0, 40);

      // flush while byte 0 is in flight
      done_dly = 50;
      write_burst(8'h40, 6);
      chk("t5_queued", 32'(count), 5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flush_cnt", 32'(count), 0);
      l0 = launches;
      d0 = dones;
      repeat (80) tick();
      chk("t5_no_launch", launches - l0, 0);
      chk("t5_b0_done", dones - d0, 1);
      chk("t5_idle_busy", 32'(tx_busy), 0);

      // reset mid-frame
      done_dly = 100;
      write_burst(8'h50, 4);
      repeat (2) tick();
      chk("t6_queued", 32'(count), 3);
      chk("t6_busy_pre", 32'(tx_busy), 1);
      do_reset();
      wr_en   = 1'b1;
      wr_data = 8'h3C;
      tick();
      wr_en = 1'b0;
      tick();
      chk("t6_send_go", 32'(tx_send_go), 1);
      chk("t6_data", 32'(tx_data), 32'h3C);
      wait_idle(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
